// File: rtl/lbp_host.sv
// lbp_host: serves the 8-bit gray image to the LBP engine and captures its results for readback.
// Build option LBP_HOST_BORDER_CHECK_EN rejects border writes and checks the final write count.
module lbp_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          done,
  output logic [AW-1:0] wr_cnt,
  output logic          err
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

  logic [7:0]       gray_mem [DEPTH];
  logic [7:0]       res_mem  [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [7:0]       gray_data_r;
  logic [7:0]       rd_data_r;
  logic             gray_ready_r;
  logic             done_r;
  logic             err_r;
  logic [AW-1:0]    wr_cnt_r;
  logic [AW-1:0]    cnt_next_s;
  logic             start_go_s;
  logic             in_idle_s;
  logic             in_serve_s;
  logic             in_done_s;
  logic             wr_take_s;
  logic             dup_err_s;
  logic             border_err_s;
  logic             count_err_s;
  logic             err_evt_s;

`ifdef LBP_HOST_BORDER_CHECK_EN
  localparam int CW = $clog2(IMG_W);
  localparam logic [AW-1:0] CNT_EXP = AW'((IMG_W - 2) * (IMG_H - 2));

  logic [AW-CW-1:0] row_s;
  logic [CW-1:0]    col_s;
  logic             border_s;

  // Border pixels lack a full 3x3 neighbourhood, so a result there is a protocol error.
  always_comb begin
    row_s    = lbp_addr[AW-1:CW];
    col_s    = lbp_addr[CW-1:0];
    border_s = (row_s == '0) || (row_s == (AW-CW)'(IMG_H - 1)) ||
               (col_s == '0) || (col_s == '1);
  end
`endif

  // Next-state, write acceptance and error-event decode.
  always_comb begin
    in_idle_s    = (state_r == ST_IDLE);
    in_serve_s   = (state_r == ST_SERVE);
    in_done_s    = (state_r == ST_DONE);
    start_go_s   = start && (in_idle_s || in_done_s);
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SERVE;
        else       state_next_s = ST_IDLE;
      end
      ST_SERVE: begin
        if (finish) state_next_s = ST_DONE;
        else        state_next_s = ST_SERVE;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_SERVE;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
`ifdef LBP_HOST_BORDER_CHECK_EN
    wr_take_s    = in_serve_s && lbp_valid && !border_s;
    border_err_s = in_serve_s && lbp_valid && border_s;
`else
    wr_take_s    = in_serve_s && lbp_valid;
    border_err_s = 1'b0;
`endif
    dup_err_s = wr_take_s && valid_r[lbp_addr];
    if (wr_take_s && (wr_cnt_r != CNT_MAX)) cnt_next_s = wr_cnt_r + AW'(1'b1);
    else                                     cnt_next_s = wr_cnt_r;
    // The count check includes a write accepted on the finish edge itself.
`ifdef LBP_HOST_BORDER_CHECK_EN
    count_err_s = in_serve_s && finish && (cnt_next_s != CNT_EXP);
`else
    count_err_s = 1'b0;
`endif
    err_evt_s = (load_en && !in_idle_s) || (lbp_valid && in_done_s) ||
                dup_err_s || border_err_s || count_err_s;
  end

  // Control registers, registered outputs and run-scoped result valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      gray_ready_r <= 1'b0;
      done_r       <= 1'b0;
      wr_cnt_r     <= '0;
      err_r        <= 1'b0;
      valid_r      <= '0;
      gray_data_r  <= 8'h00;
      rd_data_r    <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      gray_ready_r <= (state_next_s == ST_SERVE);
      done_r       <= (state_next_s == ST_DONE);
      if (start_go_s) begin
        wr_cnt_r <= '0;
        err_r    <= 1'b0;
        valid_r  <= '0;
      end else begin
        wr_cnt_r <= cnt_next_s;
        err_r    <= err_r | err_evt_s;
        if (wr_take_s) valid_r[lbp_addr] <= 1'b1;
      end
      if (in_serve_s && gray_req) gray_data_r <= gray_mem[gray_addr];
      rd_data_r <= valid_r[rd_addr] ? res_mem[rd_addr] : 8'h00;
    end
  end

  // Storage arrays carry no reset so the image survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (in_idle_s && load_en) gray_mem[load_addr] <= load_data;
    if (wr_take_s)            res_mem[lbp_addr]   <= lbp_data;
  end

  assign gray_ready = gray_ready_r;
  assign gray_data  = gray_data_r;
  assign rd_data    = rd_data_r;
  assign done       = done_r;
  assign wr_cnt     = wr_cnt_r;
  assign err        = err_r;

endmodule

// File: tb/tb_lbp_host.sv
// tb_lbp_host: randomized self-checking bench for lbp_host against a cycle-level reference model.
module tb_lbp_host;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int INTERIOR = (IMG_W - 2) * (IMG_H - 2);
`ifdef LBP_HOST_BORDER_CHECK_EN
  localparam bit BORDER_CHK = 1'b1;
`else
  localparam bit BORDER_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          done;
  logic [AW-1:0] wr_cnt;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = IDLE, 1 = SERVE, 2 = DONE.
  byte unsigned m_gray [DEPTH];
  byte unsigned m_res  [DEPTH];
  bit           m_valid[DEPTH];
  int           m_phase;
  int           m_cnt;
  bit           m_err;
  int           m_gdata;
  int           m_rdata;

  always #5 clk = ~clk;

  lbp_host #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .wr_cnt(wr_cnt), .err(err)
  );

  function automatic bit is_border(int a);
    int row;
    int col;
    row = a / IMG_W;
    col = a % IMG_W;
    return (row == 0) || (row == IMG_H - 1) || (col == 0) || (col == IMG_W - 1);
  endfunction

  task automatic clear_inputs();
    load_en = 1'b0; load_addr = '0; load_data = 8'h00; start = 1'b0;
    gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0; lbp_addr = '0;
    lbp_data = 8'h00; finish = 1'b0; rd_addr = '0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_err = 1'b0; m_gdata = 0; m_rdata = 0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // Applies the current inputs to the model, then advances one clock and settles.
  task automatic step();
    int np;
    bit e;
    bit serve;
    int a;
    np = m_phase; e = 1'b0; serve = (m_phase == 1);
    m_rdata = m_valid[rd_addr] ? int'(m_res[rd_addr]) : 0;
    if (serve && gray_req) m_gdata = int'(m_gray[gray_addr]);
    if (load_en) begin
      if (m_phase == 0) m_gray[load_addr] = load_data;
      else e = 1'b1;
    end
    if (lbp_valid && m_phase == 2) e = 1'b1;
    if (lbp_valid && serve) begin
      a = int'(lbp_addr);
      if (BORDER_CHK && is_border(a)) e = 1'b1;
      else begin
        if (m_valid[a]) e = 1'b1;
        m_res[a] = lbp_data;
        m_valid[a] = 1'b1;
        if (m_cnt < DEPTH - 1) m_cnt++;
      end
    end
    if (serve && finish) begin
      np = 2;
      if (BORDER_CHK && m_cnt != INTERIOR) e = 1'b1;
    end
    if (start && m_phase != 1) begin
      np = 1; m_cnt = 0; m_err = 1'b0; e = 1'b0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
    m_err = m_err | e;
    m_phase = np;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (gray_ready !== 1'b0) begin errors++; $display("FAIL reset_gray_ready: got %0b expected 0", gray_ready); end
    if (gray_data !== 8'h00) begin errors++; $display("FAIL reset_gray_data: got %0h expected 0", gray_data); end
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    if (wr_cnt !== '0) begin errors++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_load_read();
    logic [AW-1:0] addrs [3] = '{14'd0, 14'd1, 14'd129};
    logic [7:0]    expd  [3] = '{8'h00, 8'h01, 8'h81};
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_addr = AW'(i); load_data = 8'(i);
      step();
    end
    load_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (gray_ready !== 1'b1) begin errors++; $display("FAIL start_gray_ready: got %0b expected 1", gray_ready); end
    gray_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gray_addr = addrs[k];
      step();
      checks++;
      if (gray_data !== expd[k] || gray_data !== 8'(m_gdata)) begin
        errors++; $display("FAIL gray_read_%0d: got %0h expected %0h", k, gray_data, expd[k]);
      end
    end
    gray_req = 1'b0; gray_addr = 14'd5;
    step();
    checks++;
    if (gray_data !== 8'h81) begin errors++; $display("FAIL gray_hold: got %0h expected 81", gray_data); end
  endtask

  task automatic test_result_write();
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'hA5; rd_addr = 14'd129;
    step();
    lbp_valid = 1'b0;
    step();
    checks += 3;
    if (rd_data !== 8'hA5 || rd_data !== 8'(m_rdata)) begin errors++; $display("FAIL write_readback: got %0h expected a5", rd_data); end
    if (wr_cnt !== 14'd1) begin errors++; $display("FAIL write_cnt: got %0d expected 1", wr_cnt); end
    if (err !== 1'b0) begin errors++; $display("FAIL write_err: got %0b expected 0", err); end
    rd_addr = 14'd130;
    step();
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL unwritten_readback: got %0h expected 0", rd_data); end
  endtask

  task automatic test_double_write();
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'h5A; rd_addr = 14'd129;
    step();
    lbp_valid = 1'b0;
    step();
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL dup_err: got %0b expected 1", err); end
    if (wr_cnt !== 14'd2) begin errors++; $display("FAIL dup_cnt: got %0d expected 2", wr_cnt); end
    if (rd_data !== 8'h5A) begin errors++; $display("FAIL dup_readback: got %0h expected 5a", rd_data); end
  endtask

  task automatic interior_run(input int nwrites);
    int n;
    n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 1; r < IMG_H - 1; r++) begin
      for (int c = 1; c < IMG_W - 1; c++) begin
        if (n < nwrites) begin
          lbp_valid = 1'b1; lbp_addr = AW'(r * IMG_W + c); lbp_data = 8'($urandom);
          gray_req = 1'($urandom_range(0, 1)); gray_addr = AW'($urandom);
          rd_addr = AW'($urandom);
          step();
          n++;
        end
      end
    end
    lbp_valid = 1'b0; gray_req = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic test_full_run();
    int x;
    finish = 1'b1;
    step();
    finish = 1'b0;
    interior_run(INTERIOR);
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b expected 1", done); end
    if (gray_ready !== 1'b0) begin errors++; $display("FAIL full_gray_ready: got %0b expected 0", gray_ready); end
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %0b expected 0", err); end
    if (wr_cnt !== AW'(INTERIOR)) begin errors++; $display("FAIL full_cnt: got %0d expected %0d", wr_cnt, INTERIOR); end
    for (int k = 0; k < 8; k++) begin
      rd_addr = AW'(($urandom_range(1, IMG_H - 2)) * IMG_W + $urandom_range(1, IMG_W - 2));
      step();
      checks++;
      if (rd_data !== 8'(m_rdata)) begin errors++; $display("FAIL full_readback: got %0h expected %0h", rd_data, 8'(m_rdata)); end
    end
    x = 2 * IMG_W + 2;
    lbp_valid = 1'b1; lbp_addr = AW'(x); lbp_data = ~m_res[x];
    step();
    lbp_valid = 1'b0; rd_addr = AW'(x);
    step();
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL done_write_err: got %0b expected 1", err); end
    if (rd_data !== m_res[x]) begin errors++; $display("FAIL done_write_discard: got %0h expected %0h", rd_data, m_res[x]); end
  endtask

  task automatic test_short_run();
    interior_run(INTERIOR - 1);
    checks += 2;
    if (err !== 1'b1 || err !== m_err) begin errors++; $display("FAIL short_run_err: got %0b expected 1", err); end
    if (done !== 1'b1) begin errors++; $display("FAIL short_run_done: got %0b expected 1", done); end
  endtask

  task automatic test_load_outside_idle();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL restart_err_clear: got %0b expected 0", err); end
    load_en = 1'b1; load_addr = 14'd7; load_data = 8'hEE;
    step();
    load_en = 1'b0; gray_req = 1'b1; gray_addr = 14'd7;
    step();
    gray_req = 1'b0;
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL serve_load_err: got %0b expected 1", err); end
    if (gray_data !== 8'h07) begin errors++; $display("FAIL serve_load_ignored: got %0h expected 07", gray_data); end
  endtask

  task automatic test_border();
    logic [7:0]    exp_rd;
    logic          exp_err;
    logic [AW-1:0] exp_cnt;
`ifdef LBP_HOST_BORDER_CHECK_EN
    exp_rd = 8'h00; exp_err = 1'b1; exp_cnt = 14'd0;
`else
    exp_rd = 8'h33; exp_err = 1'b0; exp_cnt = 14'd1;
`endif
    finish = 1'b1;
    step();
    finish = 1'b0; start = 1'b1;
    step();
    start = 1'b0; lbp_valid = 1'b1; lbp_addr = 14'd0; lbp_data = 8'h33;
    step();
    lbp_valid = 1'b0; rd_addr = 14'd0;
    step();
    checks += 3;
    if (rd_data !== exp_rd || rd_data !== 8'(m_rdata)) begin errors++; $display("FAIL border_readback: got %0h expected %0h", rd_data, exp_rd); end
    if (err !== exp_err) begin errors++; $display("FAIL border_err: got %0b expected %0b", err, exp_err); end
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL border_cnt: got %0d expected %0d", wr_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] last;
    last = 14'd300;
    for (int n = 0; n < 600; n++) begin
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = AW'($urandom);
      lbp_valid = ($urandom_range(0, 2) != 0);
      lbp_addr  = ($urandom_range(0, 3) == 0) ? last : AW'($urandom);
      lbp_data  = 8'($urandom);
      rd_addr   = ($urandom_range(0, 1) == 0) ? last : AW'($urandom);
      load_en   = ($urandom_range(0, 15) == 0);
      load_addr = AW'($urandom);
      load_data = 8'($urandom);
      finish    = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 39) == 0);
      last = lbp_addr;
      step();
      checks += 6;
      if (gray_data !== 8'(m_gdata)) begin errors++; $display("FAIL rand_gray_data@%0d: got %0h expected %0h", n, gray_data, 8'(m_gdata)); end
      if (rd_data !== 8'(m_rdata)) begin errors++; $display("FAIL rand_rd_data@%0d: got %0h expected %0h", n, rd_data, 8'(m_rdata)); end
      if (wr_cnt !== AW'(m_cnt)) begin errors++; $display("FAIL rand_wr_cnt@%0d: got %0d expected %0d", n, wr_cnt, m_cnt); end
      if (err !== m_err) begin errors++; $display("FAIL rand_err@%0d: got %0b expected %0b", n, err, m_err); end
      if (done !== (m_phase == 2)) begin errors++; $display("FAIL rand_done@%0d: got %0b expected %0b", n, done, m_phase == 2); end
      if (gray_ready !== (m_phase == 1)) begin errors++; $display("FAIL rand_gray_ready@%0d: got %0b expected %0b", n, gray_ready, m_phase == 1); end
    end
    clear_inputs();
  endtask

  task automatic test_midrun_reset();
    logic [AW-1:0] last;
    last = '0;
    if (m_phase != 1) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int n = 0; n < 100; n++) begin
      lbp_valid = 1'b1;
      lbp_addr = AW'(($urandom_range(1, IMG_H - 2)) * IMG_W + $urandom_range(1, IMG_W - 2));
      lbp_data = 8'($urandom_range(1, 255));
      last = lbp_addr;
      step();
    end
    lbp_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks += 6;
    if (gray_ready !== 1'b0) begin errors++; $display("FAIL midrst_gray_ready: got %0b expected 0", gray_ready); end
    if (gray_data !== 8'h00) begin errors++; $display("FAIL midrst_gray_data: got %0h expected 0", gray_data); end
    if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data: got %0h expected 0", rd_data); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b expected 0", done); end
    if (wr_cnt !== '0) begin errors++; $display("FAIL midrst_wr_cnt: got %0d expected 0", wr_cnt); end
    if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", err); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0; gray_req = 1'b1; gray_addr = 14'd5; rd_addr = last;
    step();
    gray_req = 1'b0;
    checks += 2;
    if (gray_data !== 8'h05 || gray_data !== 8'(m_gdata)) begin errors++; $display("FAIL gray_preserved: got %0h expected 05", gray_data); end
    if (rd_data !== 8'h00) begin errors++; $display("FAIL valid_cleared: got %0h expected 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_result_write();
    test_double_write();
    test_full_run();
`ifdef LBP_HOST_BORDER_CHECK_EN
    test_short_run();
`endif
    test_load_outside_idle();
    test_border();
    test_back_to_back();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
